// File: rtl/neo_video_pkg.sv
`default_nettype none
// ============================================================================
// neo_video_pkg : shared fix-layer widths, counts and the {pal, pixel} type.
// Revision 1.0
// ============================================================================
package neo_video_pkg;

  localparam int FIX_PIX_W      = 4;
  localparam int FIX_PAL_W      = 4;
  localparam int PIX_PER_BYTE   = 2;
  localparam int BYTES_PER_TILE = 4;
  localparam int CLK_PER_PIX    = 4;

  localparam int PIX_CNT_W  = $clog2(PIX_PER_BYTE * CLK_PER_PIX);
  localparam int BYTE_IDX_W = $clog2(BYTES_PER_TILE);

  localparam logic [PIX_CNT_W-1:0] PIX_CNT_MAX   = PIX_CNT_W'(PIX_PER_BYTE * CLK_PER_PIX - 1);
  localparam logic [PIX_CNT_W-1:0] PIX_CNT_RIGHT = PIX_CNT_W'(CLK_PER_PIX);

  typedef struct packed {
    logic [FIX_PAL_W-1:0] pal;
    logic [FIX_PIX_W-1:0] pixel;
  } fix_px_t;

  // Left pixel lives in the low nibble of the S ROM byte.
  function automatic logic [FIX_PIX_W-1:0] sel_pixel(input logic [2*FIX_PIX_W-1:0] b,
                                                     input logic right);
    return right ? b[2*FIX_PIX_W-1:FIX_PIX_W] : b[FIX_PIX_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/neo_edge_det.sv
`default_nettype none
// ============================================================================
// neo_edge_det : registered edge detector, gated off until one cycle after reset.
// Revision 1.0
// ============================================================================
module neo_edge_det #(
  parameter bit BOTH_EDGES = 1'b1
) (
  input  logic CLK_24M,
  input  logic nRESET,
  input  logic i_in,
  output logic o_edge
);

  logic r_q;
  logic r_armed;
  logic w_rise;
  logic w_fall;

  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      r_q     <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_q     <= i_in;
      r_armed <= 1'b1;
    end
  end

  assign w_rise = r_armed &  i_in & ~r_q;
  assign w_fall = r_armed & ~i_in &  r_q;
  assign o_edge = w_rise | (BOTH_EDGES & w_fall);

endmodule
`default_nettype wire

// File: rtl/fix_serializer.sv
`default_nettype none
// ============================================================================
// fix_serializer : S ROM byte -> 6 MHz fix pixel stream with pipelined palette.
// Optional FIX_BLANK_EN adds nFIX_BLANK output blanking.  Revision 1.0
// ============================================================================
module fix_serializer
  import neo_video_pkg::*;
(
  input  logic                 CLK_24M,
  input  logic                 nRESET,
  input  logic                 S1H1,
  input  logic                 S2H1,
  input  logic                 LOAD,
  input  logic [23:0]          PBUS,
  input  logic [7:0]           FIXD,
`ifdef FIX_BLANK_EN
  input  logic                 nFIX_BLANK,
`endif
  output logic [FIX_PIX_W-1:0] FIX_PIXEL,
  output logic [FIX_PAL_W-1:0] FIX_PAL,
  output logic                 FIX_OPAQUE,
  output logic                 PIX_CE
);

  logic                  w_s1_edge;
  logic                  w_load_edge;
  logic                  w_blank;
  logic                  w_starved;
  logic                  w_ce;
  logic                  w_pbus_unused;
  fix_px_t               w_px;

  logic [7:0]            r_byte_buf,  w_byte_nxt;
  logic [FIX_PAL_W-1:0]  r_pal_next,  w_pal_next_nxt;
  logic [FIX_PAL_W-1:0]  r_pal_cur,   w_pal_cur_nxt;
  logic [BYTE_IDX_W-1:0] r_byte_idx,  w_idx_nxt;
  logic [PIX_CNT_W-1:0]  r_pix_cnt,   w_cnt_nxt;
  fix_px_t               r_out;
  logic                  r_opaque;
  logic                  r_ce;

  neo_edge_det #(.BOTH_EDGES(1'b1)) u_s1h1_edge (
    .CLK_24M (CLK_24M),
    .nRESET  (nRESET),
    .i_in    (S1H1),
    .o_edge  (w_s1_edge)
  );

  neo_edge_det #(.BOTH_EDGES(1'b0)) u_load_edge (
    .CLK_24M (CLK_24M),
    .nRESET  (nRESET),
    .i_in    (LOAD),
    .o_edge  (w_load_edge)
  );

`ifdef FIX_BLANK_EN
  assign w_blank = ~nFIX_BLANK;
`else
  assign w_blank = 1'b0;
`endif

  assign w_pbus_unused = ^{PBUS[23:20], PBUS[15:0]};

  // Output selection works on next-state values so a byte sampled at cycle N
  // shows up at N+1; palette follows the same path so a tile start is coherent.
  always_comb begin
    w_byte_nxt     = r_byte_buf;
    w_cnt_nxt      = r_pix_cnt;
    w_idx_nxt      = r_byte_idx;
    w_pal_next_nxt = r_pal_next;
    w_pal_cur_nxt  = r_pal_cur;

    if (w_s1_edge) begin
      w_byte_nxt = FIXD;
      w_cnt_nxt  = '0;
      w_idx_nxt  = (S1H1 && S2H1) ? '0 : r_byte_idx + 1'b1;
      if (w_idx_nxt == '0) begin
        w_pal_cur_nxt = r_pal_next;
      end
    end else if (r_pix_cnt != PIX_CNT_MAX) begin
      w_cnt_nxt = r_pix_cnt + 1'b1;
    end

    if (w_load_edge) begin
      w_pal_next_nxt = PBUS[19:16];
    end

    w_starved = !w_s1_edge && (r_pix_cnt == PIX_CNT_MAX);
    w_px.pal  = w_pal_cur_nxt;
    if (w_starved || w_blank) begin
      w_px.pixel = '0;
    end else begin
      w_px.pixel = sel_pixel(w_byte_nxt, w_cnt_nxt >= PIX_CNT_RIGHT);
    end
    w_ce = !w_starved && ((w_cnt_nxt == '0) || (w_cnt_nxt == PIX_CNT_RIGHT));
  end

  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      r_byte_buf <= '0;
      r_pal_next <= '0;
      r_pal_cur  <= '0;
      r_byte_idx <= '0;
      r_pix_cnt  <= PIX_CNT_MAX;
      r_out      <= '0;
      r_opaque   <= 1'b0;
      r_ce       <= 1'b0;
    end else begin
      r_byte_buf <= w_byte_nxt;
      r_pal_next <= w_pal_next_nxt;
      r_pal_cur  <= w_pal_cur_nxt;
      r_byte_idx <= w_idx_nxt;
      r_pix_cnt  <= w_cnt_nxt;
      r_out      <= w_px;
      r_opaque   <= (w_px.pixel != '0);
      r_ce       <= w_ce;
    end
  end

  assign FIX_PIXEL  = r_out.pixel;
  assign FIX_PAL    = r_out.pal;
  assign FIX_OPAQUE = r_opaque;
  assign PIX_CE     = r_ce;

endmodule
`default_nettype wire

// File: tb/tb_fix_serializer.sv
`default_nettype none
// ============================================================================
// tb_fix_serializer : table-driven stream/palette vectors plus hand sequences.
// Revision 1.0
// ============================================================================
module tb_fix_serializer;

  logic        CLK_24M = 1'b0;
  logic        nRESET  = 1'b0;
  logic        S1H1    = 1'b0;
  logic        S2H1    = 1'b0;
  logic        LOAD    = 1'b0;
  logic [23:0] PBUS    = 24'hF0FFFF;
  logic [7:0]  FIXD    = 8'h00;
`ifdef FIX_BLANK_EN
  logic        nFIX_BLANK = 1'b1;
`endif
  logic [3:0]  FIX_PIXEL;
  logic [3:0]  FIX_PAL;
  logic        FIX_OPAQUE;
  logic        PIX_CE;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       s1;
    logic       s2;
    logic       load;
    logic [3:0] pbus_nib;
    logic [7:0] fixd;
    logic [3:0] pix;
    logic [3:0] pal;
    logic       ce;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;

  fix_serializer dut (
    .CLK_24M    (CLK_24M),
    .nRESET     (nRESET),
    .S1H1       (S1H1),
    .S2H1       (S2H1),
    .LOAD       (LOAD),
    .PBUS       (PBUS),
    .FIXD       (FIXD),
`ifdef FIX_BLANK_EN
    .nFIX_BLANK (nFIX_BLANK),
`endif
    .FIX_PIXEL  (FIX_PIXEL),
    .FIX_PAL    (FIX_PAL),
    .FIX_OPAQUE (FIX_OPAQUE),
    .PIX_CE     (PIX_CE)
  );

  always #5 CLK_24M = ~CLK_24M;

  task automatic step();
    @(posedge CLK_24M);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] pix, input logic [3:0] pal,
                       input logic ce, input logic opq);
    total++;
    if (FIX_PIXEL !== pix || FIX_PAL !== pal || PIX_CE !== ce || FIX_OPAQUE !== opq) begin
      bad++;
      $display("FAIL %s: got pix=%h pal=%h ce=%b opq=%b, want pix=%h pal=%h ce=%b opq=%b",
               name, FIX_PIXEL, FIX_PAL, PIX_CE, FIX_OPAQUE, pix, pal, ce, opq);
    end
  endtask

  // One pixel period: four rows with identical inputs, PIX_CE only on the first.
  task automatic add_px(input logic s1, input logic s2, input logic load, input logic [3:0] nib,
                        input logic [7:0] fixd, input logic [3:0] pix, input logic [3:0] pal);
    for (int k = 0; k < 4; k++) begin
      vecs[nvec] = '{s1, s2, load, nib, fixd, pix, pal, (k == 0)};
      nvec++;
    end
  endtask

  task automatic hold_px(input string name, input logic [3:0] pix, input logic [3:0] pal,
                         input logic opq);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) step();
      check($sformatf("%s[%0d]", name, k), pix, pal, (k == 0), opq);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Tile 1 starts with LOAD(3) rising in the same cycle: tile keeps pal 0.
    add_px(1, 1, 1, 4'h3, 8'h21, 4'h1, 4'h0);
    add_px(1, 0, 1, 4'h3, 8'h21, 4'h2, 4'h0);
    add_px(0, 0, 1, 4'h3, 8'h43, 4'h3, 4'h0);
    add_px(0, 0, 0, 4'h3, 8'h43, 4'h4, 4'h0);
    // Tile 2 with simultaneous LOAD(9): takes old PAL_NEXT=3.
    add_px(1, 1, 1, 4'h9, 8'h65, 4'h5, 4'h3);
    add_px(1, 0, 0, 4'h9, 8'h65, 4'h6, 4'h3);
    add_px(0, 0, 0, 4'h9, 8'h87, 4'h7, 4'h3);
    add_px(0, 0, 0, 4'h9, 8'h87, 4'h8, 4'h3);
    // Tile 3 picks up 9; right nibble 0 is transparent.
    add_px(1, 1, 0, 4'h9, 8'h09, 4'h9, 4'h9);
    add_px(1, 0, 0, 4'h9, 8'h09, 4'h0, 4'h9);

    step();
    check("reset0", 4'h0, 4'h0, 1'b0, 1'b0);
    step();
    check("reset1", 4'h0, 4'h0, 1'b0, 1'b0);
    nRESET = 1'b1;
    step();
    check("armed", 4'h0, 4'h0, 1'b0, 1'b0);

    for (int i = 0; i < nvec; i++) begin
      S1H1 = vecs[i].s1;
      S2H1 = vecs[i].s2;
      LOAD = vecs[i].load;
      PBUS = {4'hF, vecs[i].pbus_nib, 16'hFFFF};
      FIXD = vecs[i].fixd;
      step();
      check($sformatf("vec%0d", i), vecs[i].pix, vecs[i].pal, vecs[i].ce, (vecs[i].pix != 4'h0));
    end

    // Starvation: single byte then silence.
    S1H1 = 1'b0; S2H1 = 1'b0; FIXD = 8'hA7;
    step();
    hold_px("starve_l", 4'h7, 4'h9, 1'b1);
    step();
    hold_px("starve_r", 4'hA, 4'h9, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("starved%0d", k), 4'h0, 4'h9, 1'b0, 1'b0);
    end

    // Early byte truncates the right pixel after one cycle.
    S1H1 = 1'b1; FIXD = 8'h21;
    step();
    hold_px("early_l", 4'h1, 4'h9, 1'b1);
    step();
    check("early_r", 4'h2, 4'h9, 1'b1, 1'b1);
    S1H1 = 1'b0; FIXD = 8'h43;
    step();
    check("early_next", 4'h3, 4'h9, 1'b1, 1'b1);

`ifdef FIX_BLANK_EN
    nFIX_BLANK = 1'b0; S1H1 = 1'b1; FIXD = 8'hFF;
    step();
    hold_px("blank_l", 4'h0, 4'h9, 1'b0);
    step();
    hold_px("blank_r", 4'h0, 4'h9, 1'b0);
    nFIX_BLANK = 1'b1;
`endif

    // Mid-stream reset with S1H1 high; first byte is the later falling edge.
    nRESET = 1'b0; S1H1 = 1'b1; FIXD = 8'h99;
    step();
    check("midreset", 4'h0, 4'h0, 1'b0, 1'b0);
    step();
    nRESET = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("postrst%0d", k), 4'h0, 4'h0, 1'b0, 1'b0);
    end
    S1H1 = 1'b0; FIXD = 8'h65;
    step();
    hold_px("rst_l", 4'h5, 4'h0, 1'b1);
    step();
    hold_px("rst_r", 4'h6, 4'h0, 1'b1);
    total++;
    if (dut.r_byte_idx !== 2'd1) begin
      bad++;
      $display("FAIL byte_idx: got %0d want 1", dut.r_byte_idx);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
